// File: rtl/ps2_receive.sv
// Host-side PS/2 receiver: conditions the raw pins, deframes 11-bit device frames
// and folds E0/F0 scancode prefixes into single key events.
module ps2_receive #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk_25mhz,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          fclk, fclk_q;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          ext_flag, rel_flag;

    // Conditioning registers reset to the idle-high bus level so release is edge-free.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            fclk     <= 1'b1;
            fclk_q   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            fclk_q <= fclk;
            if (clk_s2 != fclk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    fclk     <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = fclk_q & ~fclk;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (fall || state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!dat_s2) begin
                            frame_err <= 1'b1;
                        end else if (^{shreg, par}) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end
        end
    end

    // Scancode layer consumes the registered byte pulse, so key_valid lags rx_valid by one.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (parity_err || frame_err) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (rx_valid) begin
                case (rx_data)
                    8'hE0: ext_flag <= 1'b1;
                    8'hF0: rel_flag <= 1'b1;
                    default: begin
                        key_code     <= rx_data;
                        key_extended <= ext_flag;
                        key_release  <= rel_flag;
                        key_valid    <= 1'b1;
                        ext_flag     <= 1'b0;
                        rel_flag     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_receive.sv
// Scoreboard bench for ps2_receive: drives PS/2 frames on the pins and checks bytes,
// key events, error pulses, timeout latency, glitch immunity and mid-frame reset.
module tb_ps2_receive;

    localparam int unsigned HALF = 50;
    localparam int unsigned TMO  = 1500;
    localparam int unsigned FLEN = 8;

    logic       clk_25mhz = 1'b0;
    logic       resetn    = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_valid;

    ps2_receive #(
        .FILTER_LEN    (FLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy),
        .key_code    (key_code),
        .key_extended(key_extended),
        .key_release (key_release),
        .key_valid   (key_valid)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_t;

    logic [7:0] exp_rx[$];
    key_t       exp_key[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, fall_cyc = 0, rxv_cyc = 0, ferr_cyc = 0, key_lag = 0, rx_lat = 0;
    int n_rxv = 0, n_kv = 0, n_perr = 0, n_ferr = 0, n_dbl = 0, n_busy = 0;
    logic p_rxv = 1'b0, p_kv = 1'b0, p_perr = 1'b0, p_ferr = 1'b0;
    logic m_ext = 1'b0, m_rel = 1'b0;

    // One clock: sample at the falling edge and pop the scoreboard on output pulses.
    task automatic step();
        logic [7:0] e;
        key_t       k;
        key_t       a;
        @(negedge clk_25mhz);
        cyc++;
        if (busy) n_busy++;
        if ((rx_valid && p_rxv) || (key_valid && p_kv) || (parity_err && p_perr) || (frame_err && p_ferr))
            n_dbl++;
        p_rxv = rx_valid; p_kv = key_valid; p_perr = parity_err; p_ferr = frame_err;
        if (parity_err) n_perr++;
        if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
        if (rx_valid) begin
            n_rxv++; rxv_cyc = cyc; rx_lat = cyc - fall_cyc;
            n_checks++;
            if (exp_rx.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: rx_data=%02h, required no rx_valid", rx_data);
            end else begin
                e = exp_rx.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte: rx_data=%02h, required %02h", rx_data, e);
                end
            end
        end
        if (key_valid) begin
            n_kv++; key_lag = cyc - rxv_cyc;
            a = {key_code, key_extended, key_release};
            n_checks++;
            if (exp_key.size() == 0) begin
                n_fail++;
                $display("FAIL key_unexpected: code=%02h ext=%0b rel=%0b, required no key_valid",
                         key_code, key_extended, key_release);
            end else begin
                k = exp_key.pop_front();
                if (a !== k) begin
                    n_fail++;
                    $display("FAIL key_event: code=%02h ext=%0b rel=%0b, required code=%02h ext=%0b rel=%0b",
                             a.code, a.ext, a.rel, k.code, k.ext, k.rel);
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (10) step();
            ps2_clk = 1'b0;
            repeat (3) step();
            ps2_clk = 1'b1;
            repeat (HALF - 13) step();
        end else begin
            repeat (HALF) step();
        end
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        if (glitch) begin
            repeat (20) step();
            ps2_clk = 1'b1;
            repeat (3) step();
            ps2_clk = 1'b0;
            repeat (HALF - 23) step();
        end else begin
            repeat (HALF) step();
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_good, input logic stop, input bit glitch);
        logic p;
        p = par_good ? ~^b : ^b;
        if (par_good && stop) begin
            exp_rx.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                exp_key.push_back('{code: b, ext: m_ext, rel: m_rel});
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end else begin
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(stop, glitch);
        ps2_data = 1'b1;
        repeat (2 * HALF) step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (5) step();
        n_checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, busy, key_code, key_extended, key_release, key_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rx_data=%02h busy=%0b key_code=%02h, required all zero", rx_data, busy, key_code);
        end
        resetn = 1'b1;
        repeat (30) step();
        n_checks++;
        if (n_busy != 0 || n_ferr != 0 || n_rxv != 0) begin
            n_fail++;
            $display("FAIL reset_release: busy_cycles=%0d frame_errs=%0d rx=%0d, required 0 0 0", n_busy, n_ferr, n_rxv);
        end
    endtask

    task automatic test_basic();
        int r0;
        r0 = n_rxv;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (n_rxv - r0 != 1 || rx_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL basic_byte: pulses=%0d rx_data=%02h, required 1 and 1C", n_rxv - r0, rx_data);
        end
        n_checks++;
        if (key_lag != 1) begin
            n_fail++;
            $display("FAIL key_lag: %0d cycles after rx_valid, required 1", key_lag);
        end
        n_checks++;
        if (key_code !== 8'h1C || key_extended !== 1'b0 || key_release !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_key_hold: code=%02h ext=%0b rel=%0b, required 1C 0 0", key_code, key_extended, key_release);
        end
    endtask

    task automatic test_prefix();
        int k0;
        k0 = n_kv;
        send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h75, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (n_kv - k0 != 1 || key_code !== 8'h75 || key_extended !== 1'b1 || key_release !== 1'b1) begin
            n_fail++;
            $display("FAIL prefix_event: key pulses=%0d code=%02h ext=%0b rel=%0b, required 1 75 1 1",
                     n_kv - k0, key_code, key_extended, key_release);
        end
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (key_extended !== 1'b0 || key_release !== 1'b0) begin
            n_fail++;
            $display("FAIL prefix_cleared: ext=%0b rel=%0b, required 0 0", key_extended, key_release);
        end
    endtask

    task automatic test_parity_err();
        int p0, f0;
        send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (n_perr - p0 != 1 || n_ferr != f0) begin
            n_fail++;
            $display("FAIL parity_pulse: parity_err=%0d frame_err=%0d, required 1 0", n_perr - p0, n_ferr - f0);
        end
        n_checks++;
        if (rx_data !== 8'hE0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_hold: rx_data=%02h busy=%0b, required E0 0", rx_data, busy);
        end
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_frame_err();
        int p0, f0, b0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (n_ferr - f0 != 1 || n_perr != p0) begin
            n_fail++;
            $display("FAIL stop_err: frame_err=%0d parity_err=%0d, required 1 0", n_ferr - f0, n_perr - p0);
        end
        f0 = n_ferr; b0 = n_busy;
        send_bit(1'b1, 1'b0);
        repeat (2 * HALF) step();
        m_ext = 1'b0; m_rel = 1'b0;
        n_checks++;
        if (n_ferr - f0 != 1 || n_busy != b0) begin
            n_fail++;
            $display("FAIL idle_err: frame_err=%0d busy_cycles=%0d, required 1 0", n_ferr - f0, n_busy - b0);
        end
    endtask

    task automatic test_timeout();
        int f0, t, lat;
        send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
        lat = rx_lat;
        f0 = n_ferr;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        m_ext = 1'b0; m_rel = 1'b0;
        t = 0;
        while (n_ferr == f0 && t < int'(TMO) + 500) begin
            step();
            t++;
        end
        n_checks++;
        if (n_ferr - f0 != 1) begin
            n_fail++;
            $display("FAIL timeout_pulse: frame_err=%0d, required 1", n_ferr - f0);
        end
        n_checks++;
        if (ferr_cyc - fall_cyc != lat + int'(TMO)) begin
            n_fail++;
            $display("FAIL timeout_latency: %0d cycles after last fall, required %0d", ferr_cyc - fall_cyc - lat, TMO);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_busy: busy=%0b, required 0", busy);
        end
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL timeout_recover: rx_data=%02h, required 5A", rx_data);
        end
    endtask

    task automatic test_glitch_reset();
        int f0, b0, r0, k0;
        f0 = n_ferr; b0 = n_busy;
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            repeat (3) step();
            ps2_clk = 1'b1;
            repeat (20) step();
        end
        n_checks++;
        if (n_ferr != f0 || n_busy != b0) begin
            n_fail++;
            $display("FAIL idle_glitch: frame_err=%0d busy_cycles=%0d, required 0 0", n_ferr - f0, n_busy - b0);
        end
        send_frame(8'h6B, 1'b1, 1'b1, 1'b1);
        r0 = n_rxv; k0 = n_kv; f0 = n_ferr;
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        resetn = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, busy, key_code, key_extended, key_release, key_valid} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: rx_data=%02h busy=%0b key_code=%02h, required all zero", rx_data, busy, key_code);
        end
        ps2_data = 1'b1;
        resetn = 1'b1;
        m_ext = 1'b0; m_rel = 1'b0;
        repeat (2 * HALF) step();
        n_checks++;
        if (n_rxv != r0 || n_kv != k0 || n_ferr != f0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: rx=%0d key=%0d frame_err=%0d busy=%0b, required 0 0 0 0",
                     n_rxv - r0, n_kv - k0, n_ferr - f0, busy);
        end
        send_frame(8'h16, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (rx_data !== 8'h16 || key_code !== 8'h16) begin
            n_fail++;
            $display("FAIL post_reset_frame: rx_data=%02h key_code=%02h, required 16 16", rx_data, key_code);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_glitch_reset();
        n_checks++;
        if (exp_rx.size() != 0 || exp_key.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d bytes and %0d keys outstanding, required 0 0", exp_rx.size(), exp_key.size());
        end
        n_checks++;
        if (n_dbl != 0) begin
            n_fail++;
            $display("FAIL pulse_width: %0d pulses longer than one cycle, required 0", n_dbl);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
